alu_result_writeback: RTL and testbench

ALU_RESULT_WRITEBACK -- requirements
Module: alu_result_writeback

---
 rtl/alu_result_writeback.sv | 181 ++++++++++++++++++
 tb/tb_alu_result_writeback.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_writeback.sv
// ALU result writeback: latency-aligns ALU issue info, queues results in a FIFO and retires them to the register file.
// Optional combinational bypass of an empty FIFO when ALU_WB_BYPASS_EN is defined.
module alu_result_writeback #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RDY,
  input  logic [4:0]  DSTo,
  input  logic [63:0] R,
  input  logic [1:0]  SR,
  input  logic [15:0] COUT,
  input  logic        OVR,
  input  logic        Zero,
  input  logic        Sign,
  output logic        FULL,
  output logic        WE,
  output logic [4:0]  WADDR,
  output logic [63:0] WDATA,
  output logic [7:0]  WBE,
  input  logic        WACK,
  output logic [3:0]  FLAGS,
  output logic [31:0] PENDING,
  output logic        OVF
);

  // Write handshake: a write is offered while WE=1 and completes on the rising edge where WE=1 and WACK=1;
  // WADDR/WDATA/WBE stay stable until it completes.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] r;
    logic [1:0]  sr;
    logic        ovr;
    logic        cry;
    logic        zero;
    logic        sign;
  } wb_entry_t;

  function automatic logic [7:0] wbe_of(input logic [1:0] sr);
    case (sr)
      2'd0:    wbe_of = 8'h01;
      2'd1:    wbe_of = 8'h03;
      2'd2:    wbe_of = 8'h0F;
      default: wbe_of = 8'hFF;
    endcase
  endfunction

  logic [LAT-1:0] rdy_p;
  logic [4:0]     dst_p [LAT];
  logic [1:0]     sr_cap;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdy_p <= '0;
      for (int i = 0; i < LAT; i++) dst_p[i] <= '0;
    end else begin
      rdy_p[0] <= RDY;
      dst_p[0] <= DSTo;
      for (int i = 1; i < LAT; i++) begin
        rdy_p[i] <= rdy_p[i-1];
        dst_p[i] <= dst_p[i-1];
      end
    end
  end

  // SR arrives one cycle before R, so it needs one stage less of delay.
  generate
    if (LAT == 1) begin : g_sr_direct
      assign sr_cap = SR;
    end else begin : g_sr_pipe
      logic [1:0] sr_p [LAT-1];
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int i = 0; i < LAT - 1; i++) sr_p[i] <= '0;
        end else begin
          sr_p[0] <= SR;
          for (int i = 1; i < LAT - 1; i++) sr_p[i] <= sr_p[i-1];
        end
      end
      assign sr_cap = sr_p[LAT-2];
    end
  endgenerate

  logic unused_cout;
  assign unused_cout = ^COUT[14:0];

  logic      cap;
  wb_entry_t cap_e;
  assign cap   = rdy_p[LAT-1];
  assign cap_e = '{dst: dst_p[LAT-1], r: R, sr: sr_cap, ovr: OVR, cry: COUT[15], zero: Zero, sign: Sign};

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  wb_entry_t        head;
  logic             empty, fifo_full, pop, push, push_req, byp, byp_ret;

  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  assign fifo_full = (count == CW'(DEPTH));

`ifdef ALU_WB_BYPASS_EN
  assign byp = cap & empty;
`else
  assign byp = 1'b0;
`endif

  assign pop      = ~empty & WACK;
  assign byp_ret  = byp & WACK;
  assign push_req = cap & ~byp_ret;
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign push     = push_req & (~fifo_full | pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      OVF    <= 1'b0;
      FLAGS  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= cap_e;
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && fifo_full && !pop) OVF <= 1'b1;
      if (pop)          FLAGS <= {head.ovr, head.cry, head.zero, head.sign};
      else if (byp_ret) FLAGS <= {cap_e.ovr, cap_e.cry, cap_e.zero, cap_e.sign};
    end
  end

  always_comb begin
    WE    = 1'b0;
    WADDR = '0;
    WDATA = '0;
    WBE   = '0;
    if (!empty) begin
      WE    = 1'b1;
      WADDR = head.dst;
      WDATA = head.r;
      WBE   = wbe_of(head.sr);
    end else if (byp) begin
      WE    = 1'b1;
      WADDR = cap_e.dst;
      WDATA = cap_e.r;
      WBE   = wbe_of(cap_e.sr);
    end
  end

  // Occupancy includes results still in the alignment pipeline so they always find a slot.
  int occ;
  always_comb begin
    occ = int'(count);
    for (int i = 0; i < LAT; i++) occ = occ + int'(rdy_p[i]);
    FULL = (occ >= DEPTH);
  end

  always_comb begin
    PENDING = '0;
    for (int i = 0; i < LAT; i++)
      if (rdy_p[i]) PENDING[dst_p[i]] = 1'b1;
    for (int j = 0; j < DEPTH; j++)
      if (vld[j]) PENDING[mem[j].dst] = 1'b1;
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback (DEPTH=4, LAT=2, no bypass): an ALU-side model presents SR/R at the
// right delays, and every register-file write is checked against an expected queue.
module tb_alu_result_writeback;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        RESET, RDY, WACK, OVR, Zero, Sign;
  logic [4:0]  DSTo;
  logic [63:0] R;
  logic [1:0]  SR;
  logic [15:0] COUT;
  logic        FULL, WE, OVF;
  logic [4:0]  WADDR;
  logic [63:0] WDATA;
  logic [7:0]  WBE;
  logic [3:0]  FLAGS;
  logic [31:0] PENDING;

  always #5 CLK = ~CLK;

  alu_result_writeback #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .RDY(RDY), .DSTo(DSTo), .R(R), .SR(SR), .COUT(COUT),
    .OVR(OVR), .Zero(Zero), .Sign(Sign), .FULL(FULL), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .WBE(WBE), .WACK(WACK), .FLAGS(FLAGS), .PENDING(PENDING), .OVF(OVF)
  );

  typedef struct packed {
    logic        v;
    logic [63:0] r;
    logic [1:0]  sr;
    logic [3:0]  f;
  } op_t;

  op_t         p1, p2;
  logic [76:0] exp_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          n_iss;

  function automatic logic [7:0] wbe_exp(input logic [1:0] sr);
    case (sr)
      2'd0:    wbe_exp = 8'h01;
      2'd1:    wbe_exp = 8'h03;
      2'd2:    wbe_exp = 8'h0F;
      default: wbe_exp = 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: RDY/DSTo for this issue, SR from last cycle's issue, R/flags from two cycles ago.
  task automatic cyc(input logic v, input logic [4:0] d, input logic [63:0] r,
                     input logic [1:0] sr, input logic [3:0] f);
    logic [76:0] e;
    RDY  = v;
    DSTo = d;
    SR   = p1.sr;
    R    = p2.r;
    OVR  = p2.f[3];
    COUT = {p2.f[2], 15'h2A5A};
    Zero = p2.f[1];
    Sign = p2.f[0];
    #2;
    if (WE && WACK) begin
      if (exp_q.size() == 0) chk("spurious_we", WE, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("wr", {WADDR, WDATA, WBE}, e);
      end
    end
    @(posedge CLK);
    #1;
    p2 = p1;
    p1 = {v, r, sr, f};
  endtask

  task automatic op(input logic [4:0] d, input logic [63:0] r, input logic [1:0] sr, input logic [3:0] f);
    exp_q.push_back({d, r, wbe_exp(sr)});
    cyc(1'b1, d, r, sr, f);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 64'd0, 2'd0, 4'd0);
  endtask

  task automatic fill(input int base);
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      if (FULL) break;
      op(5'(base + i), 64'hA000_0000_0000_0000 + 64'(i), 2'(i), 4'(i + 8));
      n_iss++;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    RDY   = 1'b0;
    p1    = '0;
    p2    = '0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; RDY = 1'b0; DSTo = '0; R = '0; SR = '0; COUT = '0;
    OVR = 1'b0; Zero = 1'b0; Sign = 1'b0; WACK = 1'b0; p1 = '0; p2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_we", WE, 1'b0);
    chk("rst_waddr", WADDR, 5'd0);
    chk("rst_wdata", WDATA, 64'd0);
    chk("rst_wbe", WBE, 8'd0);
    chk("rst_flags", FLAGS, 4'd0);
    chk("rst_pending", PENDING, 32'd0);
    chk("rst_full", FULL, 1'b0);
    chk("rst_ovf", OVF, 1'b0);
    RESET = 1'b0;
    idle();

    // single op, WACK tied high
    WACK = 1'b1;
    op(5'd5, 64'h1234, 2'd1, 4'b0000);
    chk("t1_pend5", PENDING, 32'h0000_0020);
    idle();
    chk("t1_we_early", WE, 1'b0);
    idle();
    chk("t1_we", WE, 1'b1);
    chk("t1_waddr", WADDR, 5'd5);
    chk("t1_wbe", WBE, 8'h03);
    chk("t1_wdata", WDATA, 64'h1234);
    idle();
    chk("t1_pend_clr", PENDING, 32'd0);
    chk("t1_we_done", WE, 1'b0);

    // flags load only on pop
    WACK = 1'b0;
    op(5'd7, 64'hDEAD_BEEF_0000_0001, 2'd3, 4'b1101);
    idle();
    idle();
    chk("t2_we", WE, 1'b1);
    chk("t2_wbe", WBE, 8'hFF);
    chk("t2_flags_hold0", FLAGS, 4'd0);
    idle();
    chk("t2_flags_hold1", FLAGS, 4'd0);
    WACK = 1'b1;
    idle();
    chk("t2_flags", FLAGS, 4'b1101);
    chk("t2_we_done", WE, 1'b0);

    // back-pressure, then in-order drain
    WACK = 1'b0;
    fill(1);
    chk("t3_issued", n_iss, 4);
    repeat (2) idle();
    chk("t3_full", FULL, 1'b1);
    chk("t3_ovf", OVF, 1'b0);
    chk("t3_pend", PENDING, 32'h0000_001E);
    WACK = 1'b1;
    repeat (6) idle();
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_flags", FLAGS, 4'b1011);
    chk("t3_full_clr", FULL, 1'b0);

    // reset with three entries queued
    WACK = 1'b0;
    op(5'd10, 64'h10, 2'd0, 4'b0000);
    op(5'd11, 64'h11, 2'd1, 4'b0000);
    op(5'd12, 64'h12, 2'd2, 4'b0000);
    repeat (3) idle();
    chk("t5_pend", PENDING, 32'h0000_1C00);
    RESET = 1'b1;
    #1;
    chk("t5_we", WE, 1'b0);
    chk("t5_pend_clr", PENDING, 32'd0);
    chk("t5_flags_clr", FLAGS, 4'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    p1 = '0;
    p2 = '0;
    WACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t5_no_we", WE, 1'b0);
    end

    // overflow: issue while FULL, result dropped, OVF sticky
    WACK = 1'b0;
    fill(16);
    repeat (2) idle();
    chk("t4_full", FULL, 1'b1);
    cyc(1'b1, 5'd9, 64'h0BAD, 2'd0, 4'hF);
    repeat (2) idle();
    chk("t4_ovf", OVF, 1'b1);
    chk("t4_pend", PENDING, 32'h000F_0000);
    WACK = 1'b1;
    repeat (6) idle();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_ovf_sticky", OVF, 1'b1);
    do_reset();
    chk("t4_ovf_rst", OVF, 1'b0);

    // full FIFO with capture and pop on the same edge
    WACK = 1'b0;
    fill(24);
    repeat (2) idle();
    chk("t6_full", FULL, 1'b1);
    op(5'd20, 64'h5555_AAAA_5555_AAAA, 2'd2, 4'b0110);
    idle();
    WACK = 1'b1;
    idle();
    WACK = 1'b0;
    chk("t6_ovf", OVF, 1'b0);
    chk("t6_full_kept", FULL, 1'b1);
    chk("t6_head", WADDR, 5'd25);
    chk("t6_pend", PENDING, 32'h0E10_0000);
    WACK = 1'b1;
    repeat (6) idle();
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_flags", FLAGS, 4'b0110);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
